// File: rtl/kernel_pkg.sv
// Shared types and constants for the spike decay-kernel scheduler.
// The kernel table holds round(255 * e^-((t-1)/2)) for t = 1..7, with entry 0 meaning "no spike".
package kernel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_SEND,
        ST_DONE
    } state_e;

    localparam int T_SIZE_DEF = 3;
    localparam int Y_W_DEF    = 8;
    localparam int TAU_DEF    = 2;
    localparam int LUT_DEPTH  = 2 ** T_SIZE_DEF;

    localparam logic [Y_W_DEF-1:0] KERNEL_LUT [LUT_DEPTH] = '{
        8'd0, 8'd255, 8'd155, 8'd94, 8'd57, 8'd35, 8'd21, 8'd13
    };

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kernel_scheduler_if.sv
// Output word handshake between the kernel scheduler and its consumer.
interface kernel_scheduler_if
    import kernel_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int Y_W  = Y_W_DEF
);
    localparam int CH_W = ch_width(N_CH);

    logic            out_valid;
    logic            out_ready;
    logic [CH_W-1:0] out_ch;
    logic [Y_W-1:0]  out_val;

    modport master (output out_valid, output out_ch, output out_val, input out_ready);
    modport slave  (input out_valid, input out_ch, input out_val, output out_ready);

endinterface

// File: rtl/kernel_lut.sv
// Registered decay-kernel ROM: data_o follows addr_i one cycle after en_i is sampled high.
module kernel_lut
    import kernel_pkg::*;
#(
    parameter int T_SIZE = T_SIZE_DEF,
    parameter int Y_W    = Y_W_DEF,
    parameter int TAU    = TAU_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [T_SIZE-1:0] addr_i,
    output logic [Y_W-1:0]    data_o
);
    localparam int DEPTH = 2 ** T_SIZE;

    // The table in kernel_pkg is precomputed for one shape only; refuse anything else at elaboration.
    if (T_SIZE != T_SIZE_DEF || Y_W != Y_W_DEF || TAU != TAU_DEF) begin : g_cfg_check
        $error("kernel_lut: kernel table exists only for T_SIZE=3, Y_W=8, TAU=2");
    end

    logic [Y_W-1:0] rom [DEPTH];
    logic [Y_W-1:0] data_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rom[i] = Y_W'(KERNEL_LUT[i % LUT_DEPTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= rom[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/kernel_scheduler.sv
// Time-multiplexed decay-kernel scheduler: per-channel elapsed-step counters, one shared LUT.
// Optional KSCHED_SKIP_IDLE_EN: visit only channels whose counter is non-zero.
module kernel_scheduler
    import kernel_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int T_SIZE = T_SIZE_DEF,
    parameter int Y_W    = Y_W_DEF,
    parameter int TAU    = TAU_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CH-1:0]    spike_in,
    input  logic               tick,
    kernel_scheduler_if.master out_if,
    output logic               step_done,
    output logic               overrun
);
    localparam int                CH_W  = ch_width(N_CH);
    localparam logic [T_SIZE-1:0] T_MAX = '1;

    state_e            state_q;
    logic [T_SIZE-1:0] t_q [N_CH];
    logic [T_SIZE-1:0] t_d [N_CH];
    logic [N_CH-1:0]   pending_q, pending_d, hit;
    logic [N_CH-1:0]   visit_tick, visit_busy;
    logic [CH_W-1:0]   ch_q, first_idx, next_idx;
    logic              first_found, next_found, tick_acc;
    logic              out_valid_q, step_done_q, overrun_q;
    logic [T_SIZE-1:0] lut_addr;
    logic [Y_W-1:0]    lut_data;

    // Counters only advance on a tick accepted in IDLE; same-cycle spikes count for that tick.
    always_comb begin
        tick_acc  = tick && (state_q == ST_IDLE);
        hit       = pending_q | spike_in;
        pending_d = tick_acc ? '0 : hit;
        for (int c = 0; c < N_CH; c++) begin
            t_d[c] = t_q[c];
            if (tick_acc) begin
                if (hit[c]) begin
                    t_d[c] = T_SIZE'(1);
                end else if (t_q[c] == T_MAX) begin
                    t_d[c] = '0;
                end else if (t_q[c] != '0) begin
                    t_d[c] = t_q[c] + T_SIZE'(1);
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
`ifdef KSCHED_SKIP_IDLE_EN
            visit_tick[c] = (t_d[c] != '0);
            visit_busy[c] = (t_q[c] != '0);
`else
            visit_tick[c] = 1'b1;
            visit_busy[c] = 1'b1;
`endif
        end
    end

    // Lowest visitable channel for a new step, and the next one above ch_q within a step.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (visit_tick[c]) begin
                first_found = 1'b1;
                first_idx   = CH_W'(c);
            end
            if (visit_busy[c] && (c > int'(ch_q))) begin
                next_found = 1'b1;
                next_idx   = CH_W'(c);
            end
        end
    end

    assign lut_addr = t_q[ch_q];

    kernel_lut #(
        .T_SIZE (T_SIZE),
        .Y_W    (Y_W),
        .TAU    (TAU)
    ) u_lut (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_q == ST_LOOKUP),
        .addr_i (lut_addr),
        .data_o (lut_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            step_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            pending_q   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                t_q[c] <= '0;
            end
        end else begin
            pending_q   <= pending_d;
            step_done_q <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                t_q[c] <= t_d[c];
            end
            if (tick && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        if (first_found) begin
                            state_q <= ST_LOOKUP;
                            ch_q    <= first_idx;
                        end else begin
                            state_q     <= ST_DONE;
                            step_done_q <= 1'b1;
                        end
                    end
                end
                ST_LOOKUP: begin
                    state_q     <= ST_SEND;
                    out_valid_q <= 1'b1;
                end
                ST_SEND: begin
                    if (out_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (next_found) begin
                            state_q <= ST_LOOKUP;
                            ch_q    <= next_idx;
                        end else begin
                            state_q     <= ST_DONE;
                            step_done_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_ch    = ch_q;
    assign out_if.out_val   = lut_data;
    assign step_done        = step_done_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_kernel_scheduler.sv
// Bench for kernel_scheduler: step-level word-queue model checked every cycle, directed
// scenarios pinned with literal kernel values, then randomized spikes/ticks/backpressure/reset.
module tb_kernel_scheduler;
    localparam int N_CH   = 4;
    localparam int T_SIZE = 3;
    localparam int Y_W    = 8;
    localparam int TAU    = 2;
    localparam int T_MAX  = 7;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] spike_in;
    logic            tick;
    logic            step_done;
    logic            overrun;

    kernel_scheduler_if #(.N_CH(N_CH), .Y_W(Y_W)) bus ();

    kernel_scheduler #(
        .N_CH(N_CH), .T_SIZE(T_SIZE), .Y_W(Y_W), .TAU(TAU)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spike_in  (spike_in),
        .tick      (tick),
        .out_if    (bus.master),
        .step_done (step_done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: counters, pending spikes, and the list of words still owed for the current step.
    int KTAB [8] = '{0, 255, 155, 94, 57, 35, 21, 13};
    int tm [N_CH];
    bit pm [N_CH];
    bit m_ovr, m_busy, m_done;
    int m_cnt;
    int wq_ch[$];
    int wq_val[$];
    int obs_ch[$];
    int obs_val[$];
    int cyc = 0, tick_cyc = 0, lat = -1;
    bit lat_armed = 1'b0;

`ifdef KSCHED_SKIP_IDLE_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int find_val(input int ch);
        foreach (obs_ch[i]) if (obs_ch[i] == ch) return obs_val[i];
        return -1;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < N_CH; c++) begin
            tm[c] = 0;
            pm[c] = 1'b0;
        end
        m_ovr = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
        wq_ch.delete(); wq_val.delete();
    endtask

    task automatic model_advance(input logic [N_CH-1:0] spk, input bit tk, input bit rdy, input bit rst);
        bit idle_now;
        if (rst) begin
            model_clear();
            return;
        end
        idle_now = !m_busy;
        if (tk && !idle_now) m_ovr = 1'b1;
        if (m_busy) begin
            if (m_done) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt--;
            end else if (rdy) begin
                void'(wq_ch.pop_front());
                void'(wq_val.pop_front());
                if (wq_ch.size() > 0) m_cnt = 1;
                else m_done = 1'b1;
            end
        end
        for (int c = 0; c < N_CH; c++) if (spk[c]) pm[c] = 1'b1;
        if (tk && idle_now) begin
            for (int c = 0; c < N_CH; c++) begin
                if (pm[c]) tm[c] = 1;
                else if (tm[c] == T_MAX) tm[c] = 0;
                else if (tm[c] != 0) tm[c] = tm[c] + 1;
                pm[c] = 1'b0;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (!SKIP || tm[c] != 0) begin
                    wq_ch.push_back(c);
                    wq_val.push_back(KTAB[tm[c]]);
                end
            end
            m_busy = 1'b1;
            if (wq_ch.size() == 0) m_done = 1'b1;
            else m_cnt = 1;
        end
    endtask

    // One clock: check outputs against the model, drive the next inputs, step the model.
    task automatic cycle(input logic [N_CH-1:0] spk, input bit tk, input bit rdy, input bit rst);
        bit exp_valid;
        @(negedge clk);
        cyc++;
        exp_valid = m_busy && !m_done && (wq_ch.size() > 0) && (m_cnt == 0);
        chk("out_valid", int'(bus.out_valid), int'(exp_valid));
        if (exp_valid) begin
            chk("out_ch", int'(bus.out_ch), wq_ch[0]);
            chk("out_val", int'(bus.out_val), wq_val[0]);
        end
        chk("step_done", int'(step_done), int'(m_busy && m_done));
        chk("overrun", int'(overrun), int'(m_ovr));
        if (lat_armed && bus.out_valid) begin
            lat = cyc - tick_cyc;
            lat_armed = 1'b0;
        end
        if (bus.out_valid && rdy && !rst) begin
            obs_ch.push_back(int'(bus.out_ch));
            obs_val.push_back(int'(bus.out_val));
        end
        if (tk && !m_busy && !rst) begin
            tick_cyc  = cyc;
            lat_armed = 1'b1;
        end
        spike_in      = spk;
        tick          = tk;
        bus.out_ready = rdy;
        reset         = rst;
        model_advance(spk, tk, rdy, rst);
    endtask

    task automatic finish_step();
        for (int i = 0; i < 60 && m_busy; i++) cycle('0, 1'b0, 1'b1, 1'b0);
        chk("step_bound", int'(m_busy), 0);
    endtask

    task automatic run_step(input logic [N_CH-1:0] spk);
        obs_ch.delete(); obs_val.delete();
        cycle(spk, 1'b0, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b1, 1'b0);
        finish_step();
    endtask

    int DECAY [6] = '{155, 94, 57, 35, 21, 13};

    initial begin
        reset = 1'b1; spike_in = '0; tick = 1'b0; bus.out_ready = 1'b0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        cycle('0, 1'b0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b0, 1'b0);
        chk("reset_out_ch", int'(bus.out_ch), 0);
        chk("reset_out_val", int'(bus.out_val), 0);
        chk("reset_overrun", int'(overrun), 0);

        // Single spike on ch2, then decay down the kernel table to expiry.
        run_step(4'b0100);
        chk("first_latency", lat, 2);
        chk("spike_words", obs_ch.size(), SKIP ? 1 : 4);
        chk("spike_ch2", find_val(2), 255);
        if (!SKIP) chk("idle_ch0", find_val(0), 0);
        for (int k = 0; k < 6; k++) begin
            run_step('0);
            chk("decay_ch2", find_val(2), DECAY[k]);
        end
        run_step('0);
        chk("expired_words", obs_ch.size(), SKIP ? 0 : 4);
        chk("expired_ch2", find_val(2), SKIP ? -1 : 0);

        // Spikes on ch0 and ch3 with the tick; backpressure holds the first word.
        obs_ch.delete(); obs_val.delete();
        cycle(4'b1001, 1'b1, 1'b0, 1'b0);
        repeat (7) cycle('0, 1'b0, 1'b0, 1'b0);
        finish_step();
        chk("bp_first_ch", obs_ch.size() > 0 ? obs_ch[0] : -1, 0);
        chk("bp_first_val", obs_val.size() > 0 ? obs_val[0] : -1, 255);
        chk("bp_ch3", find_val(3), 255);

        // Tick while in SEND is ignored but flagged; a spike during busy lands on the next tick.
        obs_ch.delete(); obs_val.delete();
        cycle('0, 1'b1, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0);
        cycle(4'b0010, 1'b1, 1'b0, 1'b0);
        finish_step();
        chk("overrun_set", int'(overrun), 1);
        run_step('0);
        chk("busy_spike_ch1", find_val(1), 255);
        chk("ch0_unchanged", find_val(0), 94);

        // Reset in the middle of SEND.
        cycle('0, 1'b1, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b0, 1'b0);
        chk("abort_valid", int'(bus.out_valid), 0);
        chk("abort_overrun", int'(overrun), 0);
        chk("abort_out_ch", int'(bus.out_ch), 0);
        run_step('0);
        chk("abort_counters", obs_ch.size(), SKIP ? 0 : 4);
        if (!SKIP) chk("abort_ch1", find_val(1), 0);

        // Only ch1 active at t=3.
        run_step(4'b0010);
        run_step('0);
        run_step('0);
        chk("t3_words", obs_ch.size(), SKIP ? 1 : 4);
        chk("t3_ch1", find_val(1), 94);
        if (!SKIP && obs_ch.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_order", obs_ch[i], i);
                if (i != 1) chk("t3_idle_val", obs_val[i], 0);
            end
        end

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [N_CH-1:0] spk;
            bit tk, rdy, rst;
            spk = ($urandom_range(0, 3) == 0) ? N_CH'($urandom_range(0, 15)) : '0;
            tk  = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 599) == 0);
            cycle(spk, tk, rdy, rst);
        end
        finish_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
